// File: rtl/led_scheduler_if.sv
// Configuration bus for led_scheduler: a valid/ready write channel carrying
// a channel index, a mode and an event interval, plus an error strobe back.
interface led_scheduler_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_interval;
  logic       cfg_err;

  // Host side: issues writes, observes ready and error.
  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_mode,
    output cfg_interval,
    input  cfg_ready,
    input  cfg_err
  );

  // Scheduler side: accepts writes, reports ready and error.
  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_mode,
    input  cfg_interval,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/led_scheduler.sv
// LED scheduler: a free-running prescaler produces a tick strobe; each of the
// three channels runs OFF / ON / BLINK / TOGGLE off that tick with its own
// interval. Channel configuration arrives over a valid/ready bus and is
// applied by a two-state FSM (IDLE accepts, APPLY writes the channel).
module led_scheduler #(
  parameter int PRESCALE = 10,
  parameter int NCH      = 3
) (
  input  logic           clk,
  input  logic           rstbtn_n,
  led_scheduler_if.slave cfg,
  output logic [NCH-1:0] led,
  output logic           tick
);

  localparam int            PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST     = PW'(PRESCALE - 1);
  localparam logic [1:0]    CHAN_ILLEGAL = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_next;

  // Next prescaler phase: count up to the last phase, then wrap to zero.
  always_comb begin
    if (pre_cnt == PRE_LAST) begin
      pre_next = {PW{1'b0}};
    end else begin
      pre_next = pre_cnt + PW'(1);
    end
  end

  // Prescaler phase and registered tick; config traffic never touches these.
  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      pre_cnt <= {PW{1'b0}};
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      tick    <= (pre_next == PRE_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Configuration FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic       accept;
  logic [1:0] cap_chan;
  mode_t      cap_mode;
  logic [3:0] cap_interval;

  // Ready is a pure decode of the state so the host sees it in the same cycle.
  assign cfg.cfg_ready = (state == ST_IDLE);
  assign accept        = cfg.cfg_valid && (state == ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: an accepted write spends exactly one cycle in APPLY.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_APPLY;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_APPLY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Capture the write on acceptance; the error strobe is high for the APPLY cycle.
  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      cap_chan     <= 2'd0;
      cap_mode     <= MODE_OFF;
      cap_interval <= 4'd0;
      cfg.cfg_err  <= 1'b0;
    end else begin
      if (accept) begin
        cap_chan     <= cfg.cfg_chan;
        cap_mode     <= mode_t'(cfg.cfg_mode);
        cap_interval <= cfg.cfg_interval;
      end
      cfg.cfg_err <= accept && (cfg.cfg_chan == CHAN_ILLEGAL);
    end
  end

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  mode_t          mode        [NCH];
  logic [3:0]     interval    [NCH];
  logic [3:0]     cnt         [NCH];
  mode_t          mode_nx     [NCH];
  logic [3:0]     interval_nx [NCH];
  logic [3:0]     cnt_nx      [NCH];
  logic [NCH-1:0] led_nx;
  logic [NCH-1:0] apply_hit;
  logic [NCH-1:0] fire;

  // Which channel the APPLY cycle targets; an illegal index targets none.
  always_comb begin
    apply_hit = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      apply_hit[i] = (state == ST_APPLY) && (cap_chan == 2'(i));
    end
  end

  // Per-channel next state: APPLY wins over a coincident tick for its target.
  always_comb begin
    fire   = {NCH{1'b0}};
    led_nx = led;
    for (int i = 0; i < NCH; i++) begin
      mode_nx[i]     = mode[i];
      interval_nx[i] = interval[i];
      cnt_nx[i]      = cnt[i];
      if (apply_hit[i]) begin
        mode_nx[i]     = cap_mode;
        interval_nx[i] = cap_interval;
        cnt_nx[i]      = 4'd0;
        led_nx[i]      = 1'b0;
      end else begin
        case (mode[i])
          MODE_OFF: begin
            cnt_nx[i] = 4'd0;
            led_nx[i] = 1'b0;
          end
          MODE_ON: begin
            cnt_nx[i] = 4'd0;
            led_nx[i] = 1'b1;
          end
          MODE_BLINK, MODE_TOGGLE: begin
            if (interval[i] == 4'd0) begin
              cnt_nx[i] = 4'd0;
              led_nx[i] = 1'b0;
            end else if (tick) begin
              // Wrap on >= so a counter can never run past its interval.
              if (cnt[i] >= (interval[i] - 4'd1)) begin
                cnt_nx[i] = 4'd0;
                fire[i]   = 1'b1;
              end else begin
                cnt_nx[i] = cnt[i] + 4'd1;
                fire[i]   = 1'b0;
              end
              if (mode[i] == MODE_BLINK) begin
                led_nx[i] = fire[i];
              end else begin
                led_nx[i] = led[i] ^ fire[i];
              end
            end else begin
              cnt_nx[i] = cnt[i];
              led_nx[i] = led[i];
            end
          end
          default: begin
            cnt_nx[i] = 4'd0;
            led_nx[i] = 1'b0;
          end
        endcase
      end
    end
  end

  // Channel registers and the registered LED outputs.
  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      for (int i = 0; i < NCH; i++) begin
        mode[i]     <= MODE_OFF;
        interval[i] <= 4'd0;
        cnt[i]      <= 4'd0;
      end
      led <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        mode[i]     <= mode_nx[i];
        interval[i] <= interval_nx[i];
        cnt[i]      <= cnt_nx[i];
      end
      led <= led_nx;
    end
  end

endmodule
